led_display_monitor: RTL and testbench

Passive observer for the multiplexed 8-digit seven-segment bus produced by `led_display_driver`. It taps `led_display_seg`/`led_display_sel` and rebuilds the static 8-digit image the driver is scanning out: per-digit segment bytes, per-digit valid flags and a scan-wrap pulse. It sits beside the display pins so the remote-lab harness can read back what a user design is showing without a camera.

---
 rtl/led_display_pkg.sv | 39 +++
 rtl/seg_monitor_sync.sv | 24 ++
 rtl/led_display_monitor.sv | 135 +++++++++++++
 tb/tb_led_display_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared constants and helpers for the seven-segment display driver and monitor.
// Select-bus classification lives here so both sides agree on one-hot decoding.
package led_display_pkg;

    localparam int DIGIT_NUM = 8;
    localparam int SEG_W     = 8;
    localparam int IDX_W     = $clog2(DIGIT_NUM);

    typedef enum logic {
        S_IDLE,
        S_TRACK
    } mon_state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_ONE,
        SEL_MULTI
    } sel_class_t;

    function automatic sel_class_t classify(logic [DIGIT_NUM-1:0] v);
        if (v == '0)
            return SEL_ZERO;
        else if ((v & (v - DIGIT_NUM'(1))) == '0)
            return SEL_ONE;
        else
            return SEL_MULTI;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(logic [DIGIT_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (v[i])
                idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_monitor_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
// Used to bring the tapped display pins into the monitor clock domain.
module seg_monitor_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/led_display_monitor.sv
// Passive observer of the multiplexed seven-segment bus; rebuilds the
// static 8-digit image, per-digit liveness and a scan-wrap pulse.
module led_display_monitor
    import led_display_pkg::*;
#(
    parameter logic VALID_SIGNAL   = 1'b0,
    parameter int   STABLE_CYCLES  = 16,
    parameter int   TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       external_clk,
    input  logic                       external_rstn,
    input  logic [SEG_W-1:0]           led_display_seg,
    input  logic [DIGIT_NUM-1:0]       led_display_sel,
    output logic [DIGIT_NUM*SEG_W-1:0] digit_seg,
    output logic [DIGIT_NUM-1:0]       digit_valid,
    output logic                       frame_done,
    output logic                       sel_error
);

    localparam int              WIN_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      STABLE   = 16'(STABLE_CYCLES);

    logic [DIGIT_NUM+SEG_W-1:0] sync_bus;
    logic [DIGIT_NUM-1:0]       sel_n;
    logic [SEG_W-1:0]           seg_n;
    sel_class_t                 cls;
    logic [IDX_W-1:0]           idx_s;

    seg_monitor_sync #(
        .WIDTH (DIGIT_NUM + SEG_W)
    ) u_sync (
        .clk   (external_clk),
        .rst_n (external_rstn),
        .d     ({led_display_sel, led_display_seg}),
        .q     (sync_bus)
    );

    // Normalize so a 1 always means "pin at its active level".
    assign sel_n = sync_bus[DIGIT_NUM+SEG_W-1:SEG_W] ~^ {DIGIT_NUM{VALID_SIGNAL}};
    assign seg_n = sync_bus[SEG_W-1:0] ~^ {SEG_W{VALID_SIGNAL}};
    assign cls   = classify(sel_n);
    assign idx_s = onehot_idx(sel_n);

    mon_state_t           state, state_d;
    logic [IDX_W-1:0]     cand_idx, cand_idx_d;
    logic [SEG_W-1:0]     cand_seg, cand_seg_d;
    logic [15:0]          cnt, cnt_d;
    logic                 committed, committed_d;
    logic                 commit;
    logic [DIGIT_NUM-1:0] commit_vec;
    logic [DIGIT_NUM-1:0] seen, seen_d;
    logic [DIGIT_NUM-1:0] valid_d;
    logic [DIGIT_NUM*SEG_W-1:0] seg_d;
    logic [IDX_W-1:0]     last_idx;
    logic                 have_last;
    logic [WIN_W-1:0]     win_cnt;
    logic                 win_wrap;

    always_comb begin
        state_d     = S_IDLE;
        cand_idx_d  = cand_idx;
        cand_seg_d  = cand_seg;
        cnt_d       = '0;
        committed_d = 1'b0;
        commit      = (state == S_TRACK) && (cnt == STABLE) && !committed;
        case (cls)
            SEL_ONE: begin
                state_d = S_TRACK;
                if (state == S_TRACK && idx_s == cand_idx && seg_n == cand_seg) begin
                    cnt_d       = (cnt == STABLE) ? cnt : cnt + 16'd1;
                    committed_d = committed | commit;
                end else begin
                    cand_idx_d = idx_s;
                    cand_seg_d = seg_n;
                    cnt_d      = 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign win_wrap   = (win_cnt == WIN_LAST);
    assign commit_vec = commit ? (DIGIT_NUM'(1) << cand_idx) : '0;

    // Window wrap rebuilds liveness from what was committed during the window.
    always_comb begin
        valid_d = win_wrap ? (seen | commit_vec) : (digit_valid | commit_vec);
        seen_d  = win_wrap ? commit_vec : (seen | commit_vec);
        seg_d   = digit_seg;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (commit_vec[i])
                seg_d[i*SEG_W +: SEG_W] = cand_seg;
            else if (!valid_d[i])
                seg_d[i*SEG_W +: SEG_W] = '0;
        end
    end

    always_ff @(posedge external_clk or negedge external_rstn) begin
        if (!external_rstn) begin
            state       <= S_IDLE;
            cand_idx    <= '0;
            cand_seg    <= '0;
            cnt         <= '0;
            committed   <= 1'b0;
            seen        <= '0;
            last_idx    <= '0;
            have_last   <= 1'b0;
            win_cnt     <= '0;
            digit_seg   <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            state       <= state_d;
            cand_idx    <= cand_idx_d;
            cand_seg    <= cand_seg_d;
            cnt         <= cnt_d;
            committed   <= committed_d;
            seen        <= seen_d;
            win_cnt     <= win_wrap ? '0 : win_cnt + WIN_W'(1);
            digit_seg   <= seg_d;
            digit_valid <= valid_d;
            sel_error   <= (cls == SEL_MULTI);
            frame_done  <= commit && have_last && (cand_idx <= last_idx);
            if (commit) begin
                last_idx  <= cand_idx;
                have_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_display_monitor.sv
// Randomized and directed bench for led_display_monitor against a
// run-length reference model of the reconstructed display image.
module tb_led_display_monitor;

    localparam logic VS  = 1'b0;
    localparam int   STB = 4;
    localparam int   TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pin_sel = 8'hFF;
    logic [7:0]  pin_seg = 8'hFF;
    logic [63:0] digit_seg;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic        sel_error;

    always #5 clk = ~clk;

    led_display_monitor #(
        .VALID_SIGNAL   (VS),
        .STABLE_CYCLES  (STB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .external_clk    (clk),
        .external_rstn   (rst_n),
        .led_display_seg (pin_seg),
        .led_display_sel (pin_sel),
        .digit_seg       (digit_seg),
        .digit_valid     (digit_valid),
        .frame_done      (frame_done),
        .sel_error       (sel_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: pins reach the tracker two edges late; a digit commits
    // on the edge after its run of identical one-hot samples hits STB.
    logic [15:0] dq[$];
    logic [7:0]  m_seg[8];
    logic [7:0]  m_valid, m_seen;
    int          m_last;
    bit          m_have_last;
    int          m_edge;
    int          run;
    int          c_idx;
    logic [7:0]  c_seg;
    bit          pend;
    int          p_idx;
    logic [7:0]  p_seg;
    bit          m_frame, m_err;

    task automatic model_reset();
        dq = {16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) m_seg[i] = 8'h00;
        m_valid = 0; m_seen = 0; m_last = 0; m_have_last = 0;
        m_edge = 0; run = 0; c_idx = 0; c_seg = 0;
        pend = 0; p_idx = 0; p_seg = 0; m_frame = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic [7:0] sel, input logic [7:0] seg);
        logic [15:0] s;
        logic [7:0]  ns, nseg, cv, nv;
        int          k;
        dq.push_back({sel, seg});
        s = dq.pop_front();
        ns   = s[15:8] ~^ {8{VS}};
        nseg = s[7:0] ~^ {8{VS}};
        cv = pend ? (8'd1 << p_idx) : 8'd0;
        m_frame = pend && m_have_last && (p_idx <= m_last);
        if (pend) begin
            m_last = p_idx;
            m_have_last = 1;
            m_seg[p_idx] = p_seg;
        end
        if (m_edge % TMO == TMO - 1) begin
            nv = m_seen | cv;
            m_seen = cv;
            m_valid = nv;
            for (int i = 0; i < 8; i++) if (!nv[i]) m_seg[i] = 8'h00;
        end else begin
            m_valid |= cv;
            m_seen |= cv;
        end
        m_err = $countones(ns) > 1;
        if ($countones(ns) == 1) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (ns[i]) k = i;
            if (run > 0 && k == c_idx && nseg == c_seg) begin
                run++;
            end else begin
                run = 1; c_idx = k; c_seg = nseg;
            end
        end else begin
            run = 0;
        end
        pend = (run == STB);
        p_idx = c_idx;
        p_seg = c_seg;
        m_edge++;
    endtask

    function automatic logic [63:0] model_image();
        logic [63:0] pk;
        for (int i = 0; i < 8; i++) pk[i*8 +: 8] = m_seg[i];
        return pk;
    endfunction

    task automatic cyc(input logic [7:0] sel, input logic [7:0] seg);
        pin_sel = sel;
        pin_seg = seg;
        @(posedge clk);
        model_edge(sel, seg);
        #1;
        check("digit_seg", digit_seg, model_image());
        check("digit_valid", {56'd0, digit_valid}, {56'd0, m_valid});
        check("frame_done", {63'd0, frame_done}, {63'd0, m_frame});
        check("sel_error", {63'd0, sel_error}, {63'd0, m_err});
    endtask

    task automatic dwell(input int idx, input logic [7:0] seg, input int n);
        logic [7:0] one;
        one = 8'd1 << idx;
        repeat (n) cyc(~one, seg);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_seg", digit_seg, 64'd0);
        check("rst_valid", {56'd0, digit_valid}, 64'd0);
        check("rst_frame", {63'd0, frame_done}, 64'd0);
        check("rst_err", {63'd0, sel_error}, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int          frames;
    int          errs;
    logic [63:0] saved_seg;
    logic [7:0]  saved_valid;
    logic [7:0]  rs, rg;
    int          rn, ri;

    initial begin
        // Reset defaults with a pattern already on the pins.
        pin_sel = 8'hFE;
        pin_seg = 8'hC0;
        repeat (3) @(posedge clk);
        #1;
        check("por_seg", digit_seg, 64'd0);
        check("por_valid", {56'd0, digit_valid}, 64'd0);
        check("por_frame", {63'd0, frame_done}, 64'd0);
        check("por_err", {63'd0, sel_error}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(8'hFE, 8'hC0);
            if (i == 5) check("lat_valid_e5", {56'd0, digit_valid}, 64'd0);
        end
        check("lat_seg0_e6", {56'd0, digit_seg[7:0]}, 64'h3F);
        check("lat_valid_e6", {56'd0, digit_valid}, 64'h01);
        check("lat_frame_e6", {63'd0, frame_done}, 64'd0);

        // Full scan: one pass plus digit 0 of the next pass.
        apply_reset();
        frames = 0;
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < 10; c++) begin
                dwell(p % 8, 8'((p % 8) * 37 + 5), 1);
                frames += int'(frame_done);
            end
        end
        check("scan_valid", {56'd0, digit_valid}, 64'hFF);
        check("scan_frames", 64'(frames), 64'd1);

        // Glitch: a 3-sample dwell on digit 3 must not commit.
        saved_seg = digit_seg;
        dwell(3, 8'hFF, 3);
        repeat (5) cyc(8'hFF, 8'hFF);
        check("glitch_d3", {56'd0, digit_seg[31:24]}, {56'd0, saved_seg[31:24]});

        // Multi-hot select for two cycles.
        saved_seg = digit_seg;
        saved_valid = digit_valid;
        errs = 0;
        cyc(8'hFC, 8'h12);
        cyc(8'hFC, 8'h12);
        repeat (4) begin
            cyc(8'hFF, 8'hFF);
            errs += int'(sel_error);
        end
        check("multi_pulses", 64'(errs), 64'd2);
        check("multi_seg", digit_seg, saved_seg);
        check("multi_valid", {56'd0, digit_valid}, {56'd0, saved_valid});

        // Timeout: digit 5 stops being driven.
        for (int p = 0; p < 60; p++) begin
            if (p % 8 == 5)
                repeat (10) cyc(8'hFF, 8'h00);
            else
                dwell(p % 8, 8'((p % 8) * 37 + 5), 10);
        end
        check("tmo_valid5", {63'd0, digit_valid[5]}, 64'd0);
        check("tmo_seg5", {56'd0, digit_seg[47:40]}, 64'd0);
        check("tmo_others", {56'd0, digit_valid & 8'hDF}, 64'hDF);

        // Reset two cycles into a stable dwell on digit 2.
        dwell(2, 8'h5A, 2);
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            dwell(2, 8'h5A, 1);
            if (i == 5) check("rmid_valid_e5", {56'd0, digit_valid}, 64'd0);
        end
        check("rmid_valid_e6", {56'd0, digit_valid}, 64'h04);
        check("rmid_seg2_e6", {56'd0, digit_seg[23:16]}, 64'hA5);

        // Randomized dwells, select patterns and segment values.
        for (int t = 0; t < 300; t++) begin
            rn = $urandom_range(1, 9);
            rg = 8'($urandom);
            ri = $urandom_range(0, 9);
            if (ri < 8)
                rs = ~(8'd1 << ri);
            else if (ri == 8)
                rs = 8'hFF;
            else
                rs = 8'($urandom) & ~(8'd1 << $urandom_range(0, 3)) & ~(8'd16 << $urandom_range(0, 3));
            repeat (rn) cyc(rs, rg);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
